inst_fetch: RTL and testbench

Instruction fetch unit that supplies the 32-bit instruction word consumed by the instruction decoder/controller. It owns the program counter, issues word reads to instruction memory over a request/response handshake, and holds each fetched instruction stable until the core retires it. On retire it applies the decoder's PC selection (sequential PC+4, or a branch/jump target from the ALU) and starts the next fetch.

---
 rtl/rv32_pkg.sv | 17 +
 rtl/pc_next.sv | 21 ++
 rtl/inst_fetch.sv | 104 ++++++++++
 tb/tb_inst_fetch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 core types and constants.
// Imported by the fetch unit and its next-pc helper.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-pc selection for the fetch unit.
// Sequential pc+4 (mod 2^32), target mux and alignment check.
module pc_next
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);

    // Adder wraps at 32 bits; target is never masked, only checked.
    always_comb begin
        pc_plus4   = pc + 32'd4;
        next_pc    = pc_sel ? target : pc_plus4;
        misaligned = pc_sel && (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns pc, fetches over req/resp.
// Holds each instruction until retire, then steers pc.
module inst_fetch
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] target,
    output logic            misalign_err
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    pc_next u_pc_next (
        .pc         (pc_q),
        .pc_sel     (pc_sel),
        .target     (target),
        .next_pc    (next_pc),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned)
    );

    // State register; reset aborts whatever is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state: rvalid only counts in WAIT, retire only in HOLD.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ready) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = REQ;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign imem_req     = (state_q == REQ);
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = valid_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a 1-cycle memory model.
// A second instance with RESET_PC at the top of memory runs in lockstep.
module tb_inst_fetch;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        pc_sel;
    logic [31:0] target;

    logic        imem_req, w_req;
    logic [31:0] imem_addr, w_addr;
    logic [31:0] instr, w_instr;
    logic        instr_valid, w_valid;
    logic [31:0] pc, w_pc;
    logic [31:0] pc_plus4, w_pc_plus4;
    logic        misalign_err, w_err;

    int n_run = 0;
    int n_fail = 0;

    logic        acc = 1'b0;
    logic [31:0] acc_addr = 32'h0;
    bit          mem_auto = 1'b1;

    always #5 clk = ~clk;

    inst_fetch u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .pc_sel       (pc_sel),
        .target       (target),
        .misalign_err (misalign_err)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (w_req),
        .imem_addr    (w_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr        (w_instr),
        .instr_valid  (w_valid),
        .instr_ready  (instr_ready),
        .pc           (w_pc),
        .pc_plus4     (w_pc_plus4),
        .pc_sel       (pc_sel),
        .target       (target),
        .misalign_err (w_err)
    );

    // Memory: note acceptance on the edge, answer one cycle later.
    always @(posedge clk) begin
        if (!rst_n) begin
            acc = 1'b0;
        end else if (imem_req && imem_ready) begin
            acc      = 1'b1;
            acc_addr = imem_addr;
        end
    end

    always @(negedge clk) begin
        if (mem_auto) begin
            imem_rvalid = acc;
            imem_rdata  = acc ? {acc_addr[23:0], 8'h93} : 32'h0;
            acc         = 1'b0;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_instr"}, instr, NOP_INSTR);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_err"}, 32'(misalign_err), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        pc_sel      = 1'b0;
        target      = 32'h0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        repeat (2) cyc();

        check_reset("rst");
        check("rst_pc4", pc_plus4, 32'h4);
        check("rst_wpc", w_pc, 32'hFFFF_FFFC);
        check("rst_wpc4", w_pc_plus4, 32'h0);

        // c0: IDLE after release
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        check("c0_req", 32'(imem_req), 32'd0);

        // sequential fetches 0, 4, 8 every 3 cycles
        for (int k = 0; k < 3; k++) begin
            a = 32'(4 * k);
            cyc();
            check("seq_req", 32'(imem_req), 32'd1);
            check("seq_addr", imem_addr, a);
            check("seq_valid_lo", 32'(instr_valid), 32'd0);
            check("seq_instr_nop", instr, NOP_INSTR);
            check("wrap_addr", w_addr, a - 32'd4);
            cyc();
            check("seq_wait_req", 32'(imem_req), 32'd0);
            check("seq_wait_valid", 32'(instr_valid), 32'd0);
            cyc();
            check("seq_valid", 32'(instr_valid), 32'd1);
            check("seq_instr", instr, {a[23:0], 8'h93});
            check("seq_pc", pc, a);
            check("seq_pc4", pc_plus4, a + 32'd4);
        end

        // fetch at 12, then stall retire for 5 cycles
        cyc();
        check("r12_req", 32'(imem_req), 32'd1);
        check("r12_addr", imem_addr, 32'd12);
        cyc();
        instr_ready = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            check("hold_instr", instr, 32'h0000_0C93);
            check("hold_pc", pc, 32'd12);
            check("hold_req", 32'(imem_req), 32'd0);
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_wpc", w_pc, 32'd8);
            cyc();
        end

        // retire with jump to 0x100
        instr_ready = 1'b1;
        pc_sel      = 1'b1;
        target      = 32'h0000_0100;
        cyc();
        pc_sel     = 1'b0;
        target     = 32'h0;
        imem_ready = 1'b0;
        check("jmp_req", 32'(imem_req), 32'd1);
        check("jmp_addr", imem_addr, 32'h100);
        check("jmp_valid", 32'(instr_valid), 32'd0);
        check("jmp_wpc", w_pc, 32'h100);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("bp_req", 32'(imem_req), 32'd1);
            check("bp_addr", imem_addr, 32'h100);
        end
        cyc();
        check("bp5_req", 32'(imem_req), 32'd1);
        imem_ready = 1'b1;
        cyc();
        check("bp_wait_req", 32'(imem_req), 32'd0);
        cyc();
        check("jmp_instr", instr, 32'h0001_0093);
        check("jmp_pc", pc, 32'h100);

        // misaligned jump target halts the unit
        pc_sel = 1'b1;
        target = 32'h0000_0102;
        cyc();
        pc_sel = 1'b0;
        target = 32'h0;
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_werr", 32'(w_err), 32'd1);
        check("mis_pc", pc, 32'h100);
        check("mis_valid", 32'(instr_valid), 32'd0);
        check("mis_instr", instr, NOP_INSTR);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_err", 32'(misalign_err), 32'd1);
            check("halt_pc", pc, 32'h100);
        end

        // restart, then reset while a request is outstanding
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("rs_err", 32'(misalign_err), 32'd0);
        cyc();
        check("rs_req", 32'(imem_req), 32'd1);
        check("rs_addr", imem_addr, 32'h0);
        cyc();
        check("rs_wait", 32'(imem_req), 32'd0);
        rst_n = 1'b0;
        cyc();
        check_reset("rw");
        mem_auto    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        rst_n       = 1'b1;
        cyc();
        check("stale_instr", instr, NOP_INSTR);
        check("stale_valid", 32'(instr_valid), 32'd0);
        check("stale_req", 32'(imem_req), 32'd1);
        check("stale_addr", imem_addr, 32'h0);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_auto    = 1'b1;
        cyc();
        check("rw_wait", 32'(imem_req), 32'd0);
        cyc();
        check("rw_valid", 32'(instr_valid), 32'd1);
        check("rw_instr", instr, 32'h0000_0093);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
